seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a divide; accepted only when ready=1.
REQ-005 SHALL have port: signed_op  input  1  1 = two's-complement divide (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-006 SHALL have port: dividend  input  DATA_WIDTH  numerator; sampled with start.
REQ-007 SHALL have port: divisor  input  DATA_WIDTH  denominator; sampled with start.
REQ-008 SHALL have port: ready  output  1  high in IDLE only.
REQ-009 SHALL have port: busy  output  1  high in CALC and FIX.
REQ-010 SHALL have port: done  output  1  one-cycle pulse, high in DONE only.
REQ-011 SHALL have port: quotient  output  DATA_WIDTH  LO result, registered.
REQ-012 SHALL have port: remainder  output  DATA_WIDTH  HI result, registered.
REQ-013 SHALL have port: div_by_zero  output  1  registered flag for last completed op.

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-015 IDLE: start=1 at edge -> latch operands, sign info, zero-divisor flag; load operand magnitudes (signed_op=1) or raw values; iteration counter = DATA_WIDTH-1; go CALC.
REQ-016 CALC: one restoring shift-subtract iteration per cycle; exactly DATA_WIDTH cycles; counter 0 at edge -> FIX.
REQ-017 Trial subtract SHALL be DATA_WIDTH+1 bits wide so unsigned magnitude 2^(DATA_WIDTH-1) and 0xFFFFFFFF dividends are exact.
REQ-018 FIX: one cycle; negate quotient if signs of dividend/divisor differ; negate remainder if dividend negative (signed_op=1 only); register quotient, remainder, div_by_zero; go DONE.
REQ-019 Signed results SHALL truncate toward zero; remainder sign follows dividend.
REQ-020 Latency: start accepted at edge N -> done high during cycle after edge N+DATA_WIDTH+1 (33 for DATA_WIDTH=32).
REQ-021 Divisor = 0: full latency retained; quotient = all ones, remainder = original dividend, div_by_zero = 1.
REQ-022 Signed MIN / -1: quotient = MIN, remainder = 0, div_by_zero = 0.
REQ-023 start while not in IDLE (CALC, FIX, DONE) SHALL be ignored; operand input changes after acceptance SHALL have no effect.
REQ-024 quotient, remainder, div_by_zero SHALL hold their values from FIX until the next FIX; no intermediate values visible.
REQ-025 ready, busy, done mutually exclusive; exactly one of ready/busy/done high each cycle after reset.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) force IDLE, counter 0, quotient 0, remainder 0, div_by_zero 0, busy 0, done 0, ready 1.
REQ-027 Reset during CALC/FIX SHALL abort the operation with no done pulse; first start after rst_n release SHALL complete normally.

Structure
REQ-028 Shared package SHALL hold DATA_WIDTH default, FSM state enumeration, and divide-by-zero quotient constant (all ones).
REQ-029 Sub-module div_step SHALL be the combinational single-iteration unit: inputs partial remainder, next dividend bit, divisor; outputs new partial remainder and quotient bit.
REQ-030 Top level SHALL contain FSM, counter, operand/result registers and sign fix-up only.

Verification
REQ-031 Unsigned 100 / 7 -> quotient 14, remainder 2, done exactly 33 cycles after start edge, single-cycle pulse.
REQ-032 Signed -100 / 7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; signed 100 / -7 -> 0xFFFFFFF2, 2.
REQ-033 Unsigned 0xFFFFFFFF / 2 -> 0x7FFFFFFF, 1; signed 0x80000000 / 0xFFFFFFFF -> 0x80000000, 0.
REQ-034 5 / 0 (either mode) -> quotient 0xFFFFFFFF, remainder 5, div_by_zero 1; next 9 / 3 clears flag -> 3, 0, 0.
REQ-035 start pulsed in CALC with different operands -> ignored, first result unchanged; rst_n low 10 cycles into CALC -> outputs 0, no done, subsequent 100 / 7 correct.
REQ-036 Random signed/unsigned operands (incl. 0, 1, MIN, MAX) checked against reference model; assertions on REQ-025 every cycle.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  // Quotient fill bit reported on a zero divisor (all ones at any width).
  localparam logic DIV0_QUOT_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract iteration, purely combinational.
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] partial_rem_i,
  input  logic         dividend_bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] partial_rem_o,
  output logic         quot_bit_o
);

  // Shifted remainder needs W+1 bits; one extra bit exposes the borrow.
  logic [W+1:0] trial;

  // Trial subtract; keep the difference only when it does not borrow.
  always_comb begin
    trial = {1'b0, partial_rem_i, dividend_bit_i} - {2'b00, divisor_i};
    if (trial[W+1]) begin
      partial_rem_o = {partial_rem_i[W-2:0], dividend_bit_i};
      quot_bit_o    = 1'b0;
    end else begin
      partial_rem_o = trial[W-1:0];
      quot_bit_o    = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed/unsigned divider: one quotient bit per cycle,
// sign fix-up in a dedicated cycle, registered results.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  signed_op,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH - 1);

  state_e state_q, state_d;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dvd_q, dvd_d;       // dividend magnitude, becomes quotient
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
  logic [DATA_WIDTH-1:0] rem_q, rem_d;       // partial remainder
  logic [DATA_WIDTH-1:0] orig_q, orig_d;     // original dividend for the /0 result
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  zero_q, zero_d;
  logic [DATA_WIDTH-1:0] quo_res_q, quo_res_d;
  logic [DATA_WIDTH-1:0] rem_res_q, rem_res_d;
  logic                  dbz_q, dbz_d;

  logic [DATA_WIDTH-1:0] step_rem;
  logic                  step_bit;

  div_step #(
    .W (DATA_WIDTH)
  ) u_step (
    .partial_rem_i  (rem_q),
    .dividend_bit_i (dvd_q[DATA_WIDTH-1]),
    .divisor_i      (dvs_q),
    .partial_rem_o  (step_rem),
    .quot_bit_o     (step_bit)
  );

  // Next-state, operand capture, iteration and sign fix-up.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    orig_d    = orig_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    quo_res_d = quo_res_q;
    rem_res_d = rem_res_q;
    dbz_d     = dbz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CALC;
          cnt_d     = CNT_LOAD;
          orig_d    = dividend;
          zero_d    = (divisor == '0);
          neg_quo_d = signed_op & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
          neg_rem_d = signed_op & dividend[DATA_WIDTH-1];
          dvd_d     = (signed_op && dividend[DATA_WIDTH-1]) ? -dividend : dividend;
          dvs_d     = (signed_op && divisor[DATA_WIDTH-1])  ? -divisor  : divisor;
          rem_d     = '0;
        end
      end
      ST_CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[DATA_WIDTH-2:0], step_bit};
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FIX: begin
        state_d = ST_DONE;
        dbz_d   = zero_q;
        if (zero_q) begin
          quo_res_d = {DATA_WIDTH{DIV0_QUOT_FILL}};
          rem_res_d = orig_q;
        end else begin
          quo_res_d = neg_quo_q ? -dvd_q : dvd_q;
          rem_res_d = neg_rem_q ? -rem_q : rem_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      orig_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      quo_res_q <= '0;
      rem_res_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      orig_q    <= orig_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      quo_res_q <= quo_res_d;
      rem_res_q <= rem_res_d;
      dbz_q     <= dbz_d;
    end
  end

  assign ready       = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quo_res_q;
  assign remainder   = rem_res_q;
  assign div_by_zero = dbz_q;

endmodule
